// File: rtl/banked_regfile.sv
// Multi-bank register file with busy scoreboard and hardwired zero at bank 0 address 0.
// Define REGFILE_BYPASS_EN to forward same-cycle writes to the read ports.
module banked_regfile #(
  parameter int DATA_W = 32,
  parameter int NREG   = 32,
  parameter int NBANK  = 2,
  parameter int NRD    = 2,
  parameter int NWR    = 2,
  localparam int AW    = $clog2(NREG),
  localparam int BW    = (NBANK > 1) ? $clog2(NBANK) : 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [NRD*AW-1:0]     ra,
  input  logic [NRD*BW-1:0]     rbank,
  output logic [NRD*DATA_W-1:0] rd,
  output logic [NRD-1:0]        rd_busy,
  input  logic [NWR-1:0]        wen,
  input  logic [NWR*BW-1:0]     wbank,
  input  logic [NWR*AW-1:0]     wa,
  input  logic [NWR*DATA_W-1:0] wd,
  input  logic                  rsv_en,
  input  logic [BW-1:0]         rsv_bank,
  input  logic [AW-1:0]         rsv_addr,
  output logic [AW+BW:0]        busy_cnt
);

  localparam int NENT = NBANK * NREG;
  localparam int IW   = (NENT > 1) ? $clog2(NENT) : 1;
  localparam int CW   = AW + BW + 1;

  logic [DATA_W-1:0] mem_q [NENT];
  logic [DATA_W-1:0] mem_d [NENT];
  logic [NENT-1:0]   busy_q, busy_d;
  logic [CW-1:0]     cnt_q, cnt_d;

  logic [NWR-1:0] w_ok;
  logic [IW-1:0]  w_idx [NWR];
  logic           rsv_ok;
  logic [IW-1:0]  rsv_idx;

  function automatic logic tgt_ok(
    input logic [BW-1:0] b,
    input logic [AW-1:0] a
  );
    return (int'(b) < NBANK) && !(b == '0 && a == '0);
  endfunction

  function automatic logic [IW-1:0] flat(
    input logic [BW-1:0] b,
    input logic [AW-1:0] a
  );
    return IW'(int'(b) * NREG + int'(a));
  endfunction

  always_comb begin
    for (int w = 0; w < NWR; w++) begin
      w_ok[w]  = wen[w] &&
                 tgt_ok(wbank[w*BW +: BW], wa[w*AW +: AW]);
      w_idx[w] = flat(wbank[w*BW +: BW], wa[w*AW +: AW]);
    end
    rsv_ok  = rsv_en && tgt_ok(rsv_bank, rsv_addr);
    rsv_idx = flat(rsv_bank, rsv_addr);
  end

  // ascending port order lets the highest port win; reserve applied last
  always_comb begin
    mem_d  = mem_q;
    busy_d = busy_q;
    for (int w = 0; w < NWR; w++) begin
      if (w_ok[w]) begin
        mem_d[w_idx[w]]  = wd[w*DATA_W +: DATA_W];
        busy_d[w_idx[w]] = 1'b0;
      end
    end
    if (rsv_ok) begin
      busy_d[rsv_idx] = 1'b1;
    end
    cnt_d = '0;
    for (int i = 0; i < NENT; i++) begin
      cnt_d = cnt_d + CW'(busy_d[i]);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NENT; i++) begin
        mem_q[i] <= DATA_W'(i);
      end
      busy_q <= '0;
      cnt_q  <= '0;
    end else begin
      mem_q  <= mem_d;
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
    end
  end

  always_comb begin
    rd      = '0;
    rd_busy = '0;
    for (int r = 0; r < NRD; r++) begin
      logic [BW-1:0] b;
      logic [AW-1:0] a;
      logic [IW-1:0] ri;
      b  = rbank[r*BW +: BW];
      a  = ra[r*AW +: AW];
      ri = flat(b, a);
      if (tgt_ok(b, a)) begin
        rd[r*DATA_W +: DATA_W] = mem_q[ri];
        rd_busy[r]             = busy_q[ri];
`ifdef REGFILE_BYPASS_EN
        for (int w = 0; w < NWR; w++) begin
          if (w_ok[w] && w_idx[w] == ri) begin
            rd[r*DATA_W +: DATA_W] = wd[w*DATA_W +: DATA_W];
            rd_busy[r]             = rsv_ok && (rsv_idx == ri);
          end
        end
`endif
      end
    end
  end

  assign busy_cnt = cnt_q;

endmodule

// File: tb/tb_banked_regfile.sv
// Randomized self-checking bench for banked_regfile against an array-based model.
// Expectations honour REGFILE_BYPASS_EN when it is defined.
module tb_banked_regfile;

  localparam int DATA_W = 32;
  localparam int NREG   = 32;
  localparam int NBANK  = 2;
  localparam int NRD    = 2;
  localparam int NWR    = 2;
  localparam int AW     = 5;
  localparam int BW     = 1;
  localparam int NENT   = NBANK * NREG;

  logic                  clock = 1'b0;
  logic                  reset;
  logic [NRD*AW-1:0]     ra;
  logic [NRD*BW-1:0]     rbank;
  logic [NRD*DATA_W-1:0] rd;
  logic [NRD-1:0]        rd_busy;
  logic [NWR-1:0]        wen;
  logic [NWR*BW-1:0]     wbank;
  logic [NWR*AW-1:0]     wa;
  logic [NWR*DATA_W-1:0] wd;
  logic                  rsv_en;
  logic [BW-1:0]         rsv_bank;
  logic [AW-1:0]         rsv_addr;
  logic [AW+BW:0]        busy_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] m_mem [NENT];
  bit          m_busy [NENT];

  banked_regfile #(
    .DATA_W(DATA_W), .NREG(NREG), .NBANK(NBANK),
    .NRD(NRD), .NWR(NWR)
  ) dut (
    .clock(clock), .reset(reset),
    .ra(ra), .rbank(rbank), .rd(rd), .rd_busy(rd_busy),
    .wen(wen), .wbank(wbank), .wa(wa), .wd(wd),
    .rsv_en(rsv_en), .rsv_bank(rsv_bank), .rsv_addr(rsv_addr),
    .busy_cnt(busy_cnt)
  );

  always #5 clock = ~clock;

  function automatic bit ok(int b, int a);
    return b < NBANK && !(b == 0 && a == 0);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NENT; i++) begin
      m_mem[i]  = i;
      m_busy[i] = 0;
    end
  endtask

  task automatic model_edge();
    for (int w = 0; w < NWR; w++) begin
      int b, a;
      b = int'(wbank[w*BW +: BW]);
      a = int'(wa[w*AW +: AW]);
      if (wen[w] && ok(b, a)) begin
        m_mem[b*NREG+a]  = wd[w*DATA_W +: DATA_W];
        m_busy[b*NREG+a] = 0;
      end
    end
    if (rsv_en && ok(int'(rsv_bank), int'(rsv_addr)))
      m_busy[int'(rsv_bank)*NREG+int'(rsv_addr)] = 1;
  endtask

  function automatic int m_cnt();
    int c = 0;
    for (int i = 0; i < NENT; i++) c += int'(m_busy[i]);
    return c;
  endfunction

  function automatic logic [31:0] exp_rd(int b, int a);
    logic [31:0] v;
    if (!ok(b, a)) return 32'd0;
    v = m_mem[b*NREG+a];
`ifdef REGFILE_BYPASS_EN
    for (int w = 0; w < NWR; w++)
      if (wen[w] && int'(wbank[w*BW +: BW]) == b &&
          int'(wa[w*AW +: AW]) == a)
        v = wd[w*DATA_W +: DATA_W];
`endif
    return v;
  endfunction

  function automatic logic exp_busy(int b, int a);
    logic v;
    if (!ok(b, a)) return 1'b0;
    v = m_busy[b*NREG+a];
`ifdef REGFILE_BYPASS_EN
    for (int w = 0; w < NWR; w++)
      if (wen[w] && int'(wbank[w*BW +: BW]) == b &&
          int'(wa[w*AW +: AW]) == a)
        v = rsv_en && int'(rsv_bank) == b && int'(rsv_addr) == a;
`endif
    return v;
  endfunction

  task automatic idle_inputs();
    ra = '0; rbank = '0; wen = '0; wbank = '0;
    wa = '0; wd = '0; rsv_en = 0; rsv_bank = '0; rsv_addr = '0;
  endtask

  task automatic set_rd(int p, int b, int a);
    rbank[p*BW +: BW] = BW'(b);
    ra[p*AW +: AW]    = AW'(a);
  endtask

  task automatic set_wr(int p, int b, int a, logic [31:0] d);
    wen[p]                = 1'b1;
    wbank[p*BW +: BW]     = BW'(b);
    wa[p*AW +: AW]        = AW'(a);
    wd[p*DATA_W +: DATA_W] = d;
  endtask

  task automatic set_rsv(int b, int a);
    rsv_en   = 1'b1;
    rsv_bank = BW'(b);
    rsv_addr = AW'(a);
  endtask

  task automatic step();
    model_edge();
    @(posedge clock);
    #1;
    wen    = '0;
    rsv_en = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b0;
    model_reset();
    #12;
    n_checks++;
    if (busy_cnt !== '0) begin
      n_fail++;
      $display("FAIL reset_cnt: got %0d want 0", busy_cnt);
    end
    @(negedge clock);
    reset = 1'b1;
    set_rd(0, 1, 3);
    set_rd(1, 0, 0);
    #1;
    n_checks++;
    if (rd[31:0] !== 32'd35) begin
      n_fail++;
      $display("FAIL reset_rd_b1a3: got %0d want 35", rd[31:0]);
    end
    n_checks++;
    if (rd_busy !== 2'b00) begin
      n_fail++;
      $display("FAIL reset_busy: got %b want 00", rd_busy);
    end
    n_checks++;
    if (rd[63:32] !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_zero: got %0h want 0", rd[63:32]);
    end
  endtask

  task automatic test_zero_reg();
    set_wr(0, 0, 0, 32'hDEADBEEF);
    step();
    set_rd(0, 0, 0);
    #1;
    n_checks++;
    if (rd[31:0] !== 32'd0 || rd_busy[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL zero_b0: got %0h/%b want 0/0", rd[31:0], rd_busy[0]);
    end
    set_wr(0, 1, 0, 32'hDEADBEEF);
    step();
    set_rd(0, 1, 0);
    #1;
    n_checks++;
    if (rd[31:0] !== 32'hDEADBEEF) begin
      n_fail++;
      $display("FAIL zero_b1: got %0h want deadbeef", rd[31:0]);
    end
  endtask

  task automatic test_write_conflict();
    set_wr(0, 0, 5, 32'h11);
    set_wr(1, 0, 5, 32'h22);
    step();
    set_rd(1, 0, 5);
    #1;
    n_checks++;
    if (rd[63:32] !== 32'h22) begin
      n_fail++;
      $display("FAIL conflict: got %0h want 22", rd[63:32]);
    end
  endtask

  task automatic test_scoreboard();
    set_rsv(0, 7);
    step();
    set_rd(0, 0, 7);
    #1;
    n_checks++;
    if (rd_busy[0] !== 1'b1 || busy_cnt !== 7'd1) begin
      n_fail++;
      $display("FAIL sb_reserve: got %b/%0d want 1/1", rd_busy[0], busy_cnt);
    end
    set_wr(0, 0, 7, 32'h99);
    step();
    #1;
    n_checks++;
    if (rd_busy[0] !== 1'b0 || busy_cnt !== 7'd0 || rd[31:0] !== 32'h99) begin
      n_fail++;
      $display("FAIL sb_write: got %b/%0d/%0h want 0/0/99",
               rd_busy[0], busy_cnt, rd[31:0]);
    end
  endtask

  task automatic test_rsv_write_same();
    set_rsv(1, 4);
    set_wr(0, 1, 4, 32'hABCD);
    step();
    set_rd(0, 1, 4);
    #1;
    n_checks++;
    if (rd_busy[0] !== 1'b1 || busy_cnt !== 7'd1 || rd[31:0] !== 32'hABCD) begin
      n_fail++;
      $display("FAIL rsv_wr_same: got %b/%0d/%0h want 1/1/abcd",
               rd_busy[0], busy_cnt, rd[31:0]);
    end
    set_rsv(1, 4);
    step();
    set_rsv(0, 0);
    step();
    n_checks++;
    if (busy_cnt !== 7'd1) begin
      n_fail++;
      $display("FAIL double_rsv: got %0d want 1", busy_cnt);
    end
  endtask

  task automatic test_bypass();
    logic [31:0] want;
`ifdef REGFILE_BYPASS_EN
    want = 32'h55;
`else
    want = 32'd9;
`endif
    set_wr(0, 0, 9, 32'h55);
    set_rd(0, 0, 9);
    #1;
    n_checks++;
    if (rd[31:0] !== want || rd_busy[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL bypass: got %0h/%b want %0h/0", rd[31:0], rd_busy[0], want);
    end
    step();
    n_checks++;
    if (rd[31:0] !== 32'h55) begin
      n_fail++;
      $display("FAIL bypass_after: got %0h want 55", rd[31:0]);
    end
  endtask

  task automatic test_random();
    for (int it = 0; it < 400; it++) begin
      for (int w = 0; w < NWR; w++) begin
        if ($urandom_range(0, 1) == 1)
          set_wr(w, $urandom_range(0, 1), $urandom_range(0, 7), $urandom);
      end
      if ($urandom_range(0, 2) == 0)
        set_rsv($urandom_range(0, 1), $urandom_range(0, 7));
      for (int p = 0; p < NRD; p++) begin
        if (wen[0] && $urandom_range(0, 1) == 1)
          set_rd(p, int'(wbank[0]), int'(wa[AW-1:0]));
        else
          set_rd(p, $urandom_range(0, 1), $urandom_range(0, 7));
      end
      #1;
      for (int p = 0; p < NRD; p++) begin
        int b, a;
        b = int'(rbank[p*BW +: BW]);
        a = int'(ra[p*AW +: AW]);
        n_checks++;
        if (rd[p*DATA_W +: DATA_W] !== exp_rd(b, a) ||
            rd_busy[p] !== exp_busy(b, a)) begin
          n_fail++;
          $display("FAIL rand_read it%0d p%0d (%0d,%0d): got %0h/%b want %0h/%b",
                   it, p, b, a, rd[p*DATA_W +: DATA_W], rd_busy[p],
                   exp_rd(b, a), exp_busy(b, a));
        end
      end
      step();
      n_checks++;
      if (int'(busy_cnt) != m_cnt()) begin
        n_fail++;
        $display("FAIL rand_cnt it%0d: got %0d want %0d", it, busy_cnt, m_cnt());
      end
    end
  endtask

  task automatic test_async_reset();
    #2;
    set_wr(0, 1, 3, 32'hFFFF);
    set_rsv(1, 5);
    reset = 1'b0;
    model_reset();
    set_rd(0, 1, 3);
    set_rd(1, 1, 5);
    #1;
    n_checks++;
    if (busy_cnt !== '0 || rd[31:0] !== 32'd35) begin
      n_fail++;
      $display("FAIL async_reset: got %0d/%0d want 0/35", busy_cnt, rd[31:0]);
    end
    @(posedge clock);
    #1;
    n_checks++;
    if (rd[31:0] !== 32'd35 || rd_busy[1] !== 1'b0 || busy_cnt !== '0) begin
      n_fail++;
      $display("FAIL reset_override: got %0d/%b/%0d want 35/0/0",
               rd[31:0], rd_busy[1], busy_cnt);
    end
    @(negedge clock);
    wen    = '0;
    rsv_en = 1'b0;
    reset  = 1'b1;
  endtask

  initial begin
    test_reset();
    test_zero_reg();
    test_write_conflict();
    test_scoreboard();
    test_rsv_write_same();
    test_bypass();
    test_random();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
